// File: rtl/usb_enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usb_enc_pkg                                                  |
// | Description : Shared types and constants for the USB packet encoder.       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package usb_enc_pkg;

  typedef enum logic [1:0] {
    TOKEN     = 2'd0,
    DATA      = 2'd1,
    HANDSHAKE = 2'd2
  } pkt_kind_t;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_PID  = 3'd2;
  localparam logic [2:0] ST_TOKF = 3'd3;
  localparam logic [2:0] ST_DATA = 3'd4;
  localparam logic [2:0] ST_CRC  = 3'd5;

  // Written MSB-first; bit 0 goes on the wire first.
  localparam logic [7:0]  SYNC_BYTE  = 8'h80;
  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [4:0]  CRC5_INIT  = 5'h1f;
  localparam logic [15:0] CRC16_INIT = 16'hffff;

endpackage
`default_nettype wire

// File: rtl/usb_crc_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usb_crc_lfsr                                                 |
// | Description : Bit-serial CRC register, MSB-feedback form, all-ones init.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module usb_crc_lfsr #(
  parameter int             W    = 5,
  parameter logic [W-1:0]   POLY = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] crc
);

  logic [W-1:0] r_crc;
  logic         w_fb;

  assign w_fb = din ^ r_crc[W-1];

  always_ff @(posedge clk) begin
    if (rst || init) begin
      r_crc <= '1;
    end else if (en) begin
      r_crc <= {r_crc[W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

  assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/usb_pkt_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usb_pkt_encoder                                              |
// | Description : Serialises TOKEN/DATA/HANDSHAKE packets (SYNC..CRC) LSB-first|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module usb_pkt_encoder
  import usb_enc_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 8,
  parameter int LEN_W          = $clog2(MAX_DATA_BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pkt_valid,
  output logic                        pkt_ready,
  input  pkt_kind_t                   pkt_kind,
  input  logic [3:0]                  pid,
  input  logic [6:0]                  addr,
  input  logic [3:0]                  endp,
  input  logic [8*MAX_DATA_BYTES-1:0] data,
  input  logic [LEN_W-1:0]            data_len,
  output logic                        bit_out,
  output logic                        bit_valid,
  input  logic                        bit_ready,
  output logic                        busy,
  output logic                        done
);

  logic [2:0]                  r_state;
  logic [2:0]                  w_next;
  pkt_kind_t                   r_kind;
  logic [3:0]                  r_pid;
  logic [10:0]                 r_tok;
  logic [8*MAX_DATA_BYTES-1:0] r_data;
  logic [LEN_W-1:0]            r_len;
  logic [LEN_W-1:0]            w_len_clamp;
  logic [3:0]                  r_bit_cnt;
  logic [LEN_W-1:0]            r_byte_cnt;
  logic                        r_done;
  logic                        w_accept;
  logic                        w_hs;
  logic                        w_field_last;
  logic                        w_bit;
  logic [7:0]                  w_pid_byte;
  logic [4:0]                  w_crc5;
  logic [15:0]                 w_crc16;

  assign pkt_ready   = (r_state == ST_IDLE);
  assign busy        = ~pkt_ready;
  assign bit_valid   = (r_state != ST_IDLE);
  assign bit_out     = w_bit;
  assign done        = r_done;
  assign w_accept    = pkt_valid && pkt_ready;
  assign w_hs        = bit_valid && bit_ready;
  assign w_pid_byte  = {~r_pid, r_pid};
  assign w_len_clamp = (data_len > LEN_W'(MAX_DATA_BYTES)) ? LEN_W'(MAX_DATA_BYTES) : data_len;

  // Token fields and payload are shift registers, so the current bit is always bit 0.
  always_comb begin
    w_bit = 1'b0;
    case (r_state)
      ST_SYNC: w_bit = SYNC_BYTE[r_bit_cnt[2:0]];
      ST_PID:  w_bit = w_pid_byte[r_bit_cnt[2:0]];
      ST_TOKF: w_bit = r_tok[0];
      ST_DATA: w_bit = r_data[0];
      ST_CRC:  w_bit = (r_kind == TOKEN) ? ~w_crc5[3'd4 - r_bit_cnt[2:0]]
                                          : ~w_crc16[4'd15 - r_bit_cnt];
      default: w_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_field_last = 1'b0;
    case (r_state)
      ST_SYNC, ST_PID: w_field_last = (r_bit_cnt == 4'd7);
      ST_TOKF:         w_field_last = (r_bit_cnt == 4'd10);
      ST_DATA:         w_field_last = (r_bit_cnt == 4'd7) && (r_byte_cnt == r_len - LEN_W'(1));
      ST_CRC:          w_field_last = (r_kind == TOKEN) ? (r_bit_cnt == 4'd4) : (r_bit_cnt == 4'd15);
      default:         w_field_last = 1'b0;
    endcase
  end

  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_SYNC: w_next = ST_PID;
      ST_PID: begin
        if (r_kind == TOKEN)     w_next = ST_TOKF;
        else if (r_kind == DATA) w_next = (r_len != '0) ? ST_DATA : ST_CRC;
        else                     w_next = ST_IDLE;
      end
      ST_TOKF: w_next = ST_CRC;
      ST_DATA: w_next = ST_CRC;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_kind     <= TOKEN;
      r_pid      <= '0;
      r_tok      <= '0;
      r_data     <= '0;
      r_len      <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state    <= ST_SYNC;
        r_kind     <= pkt_kind;
        r_pid      <= pid;
        r_tok      <= {endp, addr};
        r_data     <= data;
        r_len      <= w_len_clamp;
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
      end else if (w_hs) begin
        if (r_state == ST_TOKF) r_tok  <= r_tok >> 1;
        if (r_state == ST_DATA) r_data <= r_data >> 1;
        if (w_field_last) begin
          r_state    <= w_next;
          r_bit_cnt  <= '0;
          r_byte_cnt <= '0;
          r_done     <= (w_next == ST_IDLE);
        end else if ((r_state == ST_DATA) && (r_bit_cnt == 4'd7)) begin
          r_bit_cnt  <= '0;
          r_byte_cnt <= r_byte_cnt + LEN_W'(1);
        end else begin
          r_bit_cnt  <= r_bit_cnt + 4'd1;
        end
      end
    end
  end

  usb_crc_lfsr #(.W(5), .POLY(CRC5_POLY)) u_crc5 (
    .clk  (clk),
    .rst  (rst),
    .init (w_accept),
    .en   (w_hs && (r_state == ST_TOKF)),
    .din  (w_bit),
    .crc  (w_crc5)
  );

  usb_crc_lfsr #(.W(16), .POLY(CRC16_POLY)) u_crc16 (
    .clk  (clk),
    .rst  (rst),
    .init (w_accept),
    .en   (w_hs && (r_state == ST_DATA)),
    .din  (w_bit),
    .crc  (w_crc16)
  );

endmodule
`default_nettype wire

// File: tb/tb_usb_pkt_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_usb_pkt_encoder                                           |
// | Description : Table-driven + scoreboard bench for usb_pkt_encoder.         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_usb_pkt_encoder;
  import usb_enc_pkg::*;

  localparam int MAX = 8;
  localparam int LW  = $clog2(MAX + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pkt_valid = 1'b0;
  logic              pkt_ready;
  pkt_kind_t         pkt_kind = TOKEN;
  logic [3:0]        pid = '0;
  logic [6:0]        addr = '0;
  logic [3:0]        endp = '0;
  logic [8*MAX-1:0]  data = '0;
  logic [LW-1:0]     data_len = '0;
  logic              bit_out;
  logic              bit_valid;
  logic              bit_ready = 1'b1;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  usb_pkt_encoder #(.MAX_DATA_BYTES(MAX)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_kind(pkt_kind), .pid(pid), .addr(addr), .endp(endp), .data(data),
    .data_len(data_len), .bit_out(bit_out), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .busy(busy), .done(done)
  );

  typedef struct {
    pkt_kind_t  kind;
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
    int         len;
    int         mode;
    int         exp_bits;
  } vec_t;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  rdy_mode = 0;
  bit  exp_q[$];
  bit  rx_bits[1024];
  int  rx_n = 0;
  bit  done_seen = 0;
  int  done_cyc = 0;
  bit  stalled = 0;
  bit  stall_bit = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reflected (shift-right) CRC model; complement is sent from bit 0 upward.
  task automatic push_expected(input pkt_kind_t k, input logic [3:0] p, input logic [6:0] a,
                               input logic [3:0] e, input logic [8*MAX-1:0] d, input int len);
    logic [7:0]  pb;
    logic [4:0]  c5;
    logic [15:0] c16;
    logic        b;
    logic        fb;
    int          l;
    pb = {~p, p};
    for (int i = 0; i < 8; i++) exp_q.push_back(i == 7);
    for (int i = 0; i < 8; i++) exp_q.push_back(pb[i]);
    if (k == TOKEN) begin
      c5 = 5'h1f;
      for (int i = 0; i < 11; i++) begin
        b = (i < 7) ? a[i] : e[i-7];
        exp_q.push_back(b);
        fb = c5[0] ^ b;
        c5 = c5 >> 1;
        if (fb) c5 = c5 ^ 5'h14;
      end
      for (int i = 0; i < 5; i++) exp_q.push_back(~c5[i]);
    end else if (k == DATA) begin
      l = (len > MAX) ? MAX : len;
      c16 = 16'hffff;
      for (int i = 0; i < 8*l; i++) begin
        b = d[i];
        exp_q.push_back(b);
        fb = c16[0] ^ b;
        c16 = c16 >> 1;
        if (fb) c16 = c16 ^ 16'ha001;
      end
      for (int i = 0; i < 16; i++) exp_q.push_back(~c16[i]);
    end
  endtask

  task automatic send(input pkt_kind_t k, input logic [3:0] p, input logic [6:0] a,
                      input logic [3:0] e, input logic [8*MAX-1:0] d, input int len,
                      output int first_cyc, output bit done_at_acc);
    int n;
    pkt_kind = k; pid = p; addr = a; endp = e; data = d; data_len = LW'(len);
    pkt_valid = 1'b1;
    first_cyc = 0;
    done_at_acc = 1'b0;
    n = 0;
    while (pkt_ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      check("accept_timeout", 0, 1);
      pkt_valid = 1'b0;
      return;
    end
    done_at_acc = done;
    @(posedge clk); #1;
    push_expected(k, p, a, e, d, len);
    first_cyc = cyc;
    check("first_bit_latency", {31'd0, bit_valid}, 1);
    check("busy_after_accept", {30'd0, busy, pkt_ready}, 2);
    pkt_valid = 1'b0;
    pkt_kind = pkt_kind_t'($urandom_range(0, 2));
    pid = 4'($urandom); addr = 7'($urandom); endp = 4'($urandom);
    data = {$urandom, $urandom}; data_len = LW'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_seen && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_seen) check("done_timeout", 0, 1);
  endtask

  function automatic logic [15:0] rx_field(input int start, input int n);
    logic [15:0] f;
    f = '0;
    for (int j = 0; j < n; j++) f[j] = rx_bits[start+j];
    return f;
  endfunction

  initial forever begin
    @(posedge clk); #2;
    case (rdy_mode)
      0:       bit_ready = 1'b1;
      1:       bit_ready = ~bit_ready;
      default: bit_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {30'd0, bit_valid, bit_out}, {30'd0, 1'b1, stall_bit});
      if (busy) check("no_bubble", {31'd0, bit_valid}, 1);
      if (bit_valid && bit_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          check("serial_bit", {31'd0, bit_out}, {31'd0, exp_q.pop_front()});
        end
        if (rx_n < 1024) rx_bits[rx_n] = bit_out;
        rx_n++;
      end
      stalled   = bit_valid && !bit_ready;
      stall_bit = bit_out;
      if (done) begin
        check("done_queue_empty", exp_q.size(), 0);
        check("done_ready", {31'd0, pkt_ready}, 1);
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  initial begin
    vec_t vecs[7];
    int   fc;
    bit   dacc;
    int   n;
    logic [15:0] pid_tok_exp;
    logic [15:0] crc_tok_exp;
    logic [15:0] pid_dat_exp;

    vecs[0] = '{TOKEN,     4'h1, 7'h15, 4'he, 0,       0, 32};
    vecs[1] = '{DATA,      4'h3, 7'h00, 4'h0, 0,       0, 32};
    vecs[2] = '{HANDSHAKE, 4'h2, 7'h00, 4'h0, 0,       0, 16};
    vecs[3] = '{DATA,      4'hb, 7'h00, 4'h0, MAX,     1, 32 + 8*MAX};
    vecs[4] = '{DATA,      4'h3, 7'h00, 4'h0, 3,       2, 56};
    vecs[5] = '{TOKEN,     4'h9, 7'h7f, 4'h0, 0,       2, 32};
    vecs[6] = '{DATA,      4'hb, 7'h00, 4'h0, MAX + 1, 0, 32 + 8*MAX};
    pid_tok_exp = 16'h00e1;
    crc_tok_exp = 16'h001d;
    pid_dat_exp = 16'h00c3;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_pkt_ready", {31'd0, pkt_ready}, 1);
    check("rst_bit_valid", {31'd0, bit_valid}, 0);
    check("rst_bit_out",   {31'd0, bit_out},   0);
    check("rst_busy",      {31'd0, busy},      0);
    check("rst_done",      {31'd0, done},      0);

    for (int i = 0; i < 7; i++) begin
      rdy_mode  = vecs[i].mode;
      rx_n      = 0;
      done_seen = 1'b0;
      send(vecs[i].kind, vecs[i].pid, vecs[i].addr, vecs[i].endp,
           {$urandom, $urandom}, vecs[i].len, fc, dacc);
      wait_done();
      check("bit_count", rx_n, vecs[i].exp_bits);
      if (vecs[i].mode == 0) check("done_latency", done_cyc - fc, vecs[i].exp_bits);
      if (i == 0) begin
        check("token_pid_field", rx_field(8, 8), pid_tok_exp);
        check("token_crc_field", rx_field(27, 5), crc_tok_exp);
      end
      if (i == 1) begin
        check("zlp_pid_field", rx_field(8, 8), pid_dat_exp);
        check("zlp_crc_field", rx_field(16, 16), 0);
      end
      rdy_mode = 0;
      @(posedge clk); #1;
      check("idle_after_pkt", {29'd0, pkt_ready, busy, bit_valid}, 4);
    end

    // Reset while the 10th bit of a DATA packet is on the wire.
    rdy_mode  = 0;
    rx_n      = 0;
    done_seen = 1'b0;
    send(DATA, 4'h3, 7'h00, 4'h0, {$urandom, $urandom}, MAX, fc, dacc);
    n = 0;
    while (rx_n < 9 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_bit10", rx_n, 9);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_bit_valid", {31'd0, bit_valid}, 0);
    check("midrst_pkt_ready", {31'd0, pkt_ready}, 1);
    check("midrst_done",      {31'd0, done},      0);
    rst = 1'b0;
    exp_q.delete();
    rx_n      = 0;
    done_seen = 1'b0;
    send(TOKEN, 4'hd, 7'h2a, 4'h5, '0, 0, fc, dacc);
    wait_done();
    check("post_rst_bits", rx_n, 32);

    // Back-to-back: pkt_valid stays high, second request taken in the done cycle.
    rx_n      = 0;
    done_seen = 1'b0;
    send(TOKEN, 4'h1, 7'h15, 4'he, '0, 0, fc, dacc);
    send(TOKEN, 4'h9, 7'h03, 4'h7, '0, 0, fc, dacc);
    check("b2b_done_at_accept", {31'd0, dacc}, 1);
    check("b2b_first_bits", rx_n, 32);
    rx_n      = 0;
    done_seen = 1'b0;
    wait_done();
    check("b2b_second_bits", rx_n, 32);
    check("b2b_done_latency", done_cyc - fc, 32);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
